// File: rtl/md5_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | md5_pkg : shared MD5 constants, padder FSM state type and small helpers     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package md5_pkg;

    localparam int             MD5_BLOCK_W    = 512;
    localparam int             MD5_WORD_W     = 32;
    localparam logic [7:0]     MD5_PAD_BYTE   = 8'h80;
    localparam int             MD5_MAX_SINGLE = 55;
    localparam logic [127:0]   MD5_IV         = 128'h67452301efcdab8998badcfe10325476;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } pad_state_t;

    // Byte count carried by a word: 4 unless it is the last word with a partial count.
    function automatic logic [2:0] word_bytes(input logic last, input logic [1:0] nbytes);
        return (last && (nbytes != 2'd0)) ? {1'b0, nbytes} : 3'd4;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md5_pad_lane.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | md5_pad_lane : one 32-bit lane of the padded block (data / 0x80 / 0 / len)  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module md5_pad_lane
    import md5_pkg::*;
(
    input  logic [3:0]            lane,
    input  logic [MD5_WORD_W-1:0] word,
    input  logic [5:0]            len,
    output logic [MD5_WORD_W-1:0] padded
);

    logic [5:0] idx;

    always_comb begin
        padded = '0;
        idx    = '0;
        if (lane == 4'd14) begin
            padded = {23'd0, len, 3'b000};
        end else if (lane != 4'd15) begin
            for (int b = 0; b < 4; b++) begin
                idx = {lane, 2'(b)};
                if (idx < len) begin
                    padded[8*b +: 8] = word[8*b +: 8];
                end else if (idx == len) begin
                    padded[8*b +: 8] = MD5_PAD_BYTE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/md5_msg_padder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | md5_msg_padder : packs a word stream into one MD5-padded 512-bit block      |
// | Option MD5_PAD_OVERFLOW_EN: err_o pulse instead of truncating long messages |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int MAX_LEN_BYTES = MD5_MAX_SINGLE
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic [MD5_WORD_W-1:0]  data_i,
    input  logic                   valid_i,
    input  logic                   last_i,
    input  logic [1:0]             nbytes_i,
    output logic                   ready_o,
    output logic                   valid_o,
`ifdef MD5_PAD_OVERFLOW_EN
    output logic                   err_o,
`endif
    output logic [MD5_BLOCK_W-1:0] wb_o
);

    localparam logic [6:0] MAX_L = 7'(MAX_LEN_BYTES);

    pad_state_t            state;
    logic [MD5_WORD_W-1:0] buffer    [14];
    logic [MD5_WORD_W-1:0] lane_word [16];
    logic [3:0]            wcnt;
    logic [5:0]            len;
    logic [6:0]            sum;
    logic                  over;
    logic [5:0]            len_next;
    logic [MD5_BLOCK_W-1:0] pad_block;

    assign ready_o  = en_i && (state == ACCUM);
    assign valid_o  = en_i && (state == EMIT);

    // Length saturates at the limit, so every word after the limit is also "over".
    assign sum      = 7'(len) + 7'(word_bytes(last_i, nbytes_i));
    assign over     = sum > MAX_L;
    assign len_next = over ? MAX_L[5:0] : sum[5:0];

    // The incoming word is merged into its lane so the last word can be padded on acceptance.
    for (genvar k = 0; k < 16; k++) begin : g_lane
        if (k < 14) begin : g_data
            assign lane_word[k] = (wcnt == 4'(k)) ? data_i : buffer[k];
        end else begin : g_len
            assign lane_word[k] = '0;
        end
        md5_pad_lane u_lane (
            .lane   (4'(k)),
            .word   (lane_word[k]),
            .len    (len_next),
            .padded (pad_block[32*k +: 32])
        );
    end

`ifdef MD5_PAD_OVERFLOW_EN
    logic err_q;
    assign err_o = en_i && err_q;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ACCUM;
            wcnt  <= '0;
            len   <= '0;
            wb_o  <= '0;
            for (int k = 0; k < 14; k++) buffer[k] <= '0;
`ifdef MD5_PAD_OVERFLOW_EN
            err_q <= 1'b0;
`endif
        end else if (en_i) begin
`ifdef MD5_PAD_OVERFLOW_EN
            err_q <= 1'b0;
`endif
            case (state)
                ACCUM: begin
                    if (valid_i) begin
                        if (last_i) begin
                            wcnt <= '0;
                            len  <= '0;
                            for (int k = 0; k < 14; k++) buffer[k] <= '0;
`ifdef MD5_PAD_OVERFLOW_EN
                            if (over) begin
                                err_q <= 1'b1;
                            end else begin
                                wb_o  <= pad_block;
                                state <= EMIT;
                            end
`else
                            wb_o  <= pad_block;
                            state <= EMIT;
`endif
                        end else begin
                            for (int k = 0; k < 14; k++) begin
                                if (wcnt == 4'(k)) buffer[k] <= data_i;
                            end
                            if (wcnt < 4'd14) wcnt <= wcnt + 4'd1;
                            len <= len_next;
                        end
                    end
                end
                EMIT:    state <= ACCUM;
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md5_msg_padder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_md5_msg_padder : randomized bench with a byte-level padding model        |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_md5_msg_padder;

    localparam int MAX = 55;
    typedef logic [7:0] bytes_t [$];

    logic         clk = 1'b0;
    logic         rst, dir_en, rnd_en, rand_mode;
    logic         en, valid, last, ready, valid_out;
    logic [31:0]  data;
    logic [1:0]   nbytes;
    logic [511:0] wb;
`ifdef MD5_PAD_OVERFLOW_EN
    logic         err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    int exp_err  = 0;
    logic [511:0] got_q  [$];
    logic [511:0] expv_q [$];

    assign en = rand_mode ? rnd_en : dir_en;

    md5_msg_padder #(.MAX_LEN_BYTES(MAX)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .en_i     (en),
        .data_i   (data),
        .valid_i  (valid),
        .last_i   (last),
        .nbytes_i (nbytes),
        .ready_o  (ready),
        .valid_o  (valid_out),
`ifdef MD5_PAD_OVERFLOW_EN
        .err_o    (err),
`endif
        .wb_o     (wb)
    );

    always #5 clk = ~clk;

    // Enable is changed just after the falling edge; outputs are sampled 2 ns later.
    always @(negedge clk) begin
        #1;
        rnd_en = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        #3;
        if (valid_out) got_q.push_back(wb);
`ifdef MD5_PAD_OVERFLOW_EN
        if (err) err_cnt++;
`endif
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Padding straight from the byte-level rules: data, 0x80, zeros, 64-bit bit length.
    function automatic logic [511:0] model(input bytes_t m);
        int           eff;
        logic [511:0] b;
        eff = (m.size() > MAX) ? MAX : m.size();
        b   = '0;
        for (int j = 0; j < eff; j++) b[8*j +: 8] = m[j];
        b[8*eff +: 8] = 8'h80;
        b[511:448]    = 64'(eff * 8);
        return b;
    endfunction

    function automatic bytes_t const_msg(input int n, input logic [7:0] v);
        bytes_t q;
        for (int j = 0; j < n; j++) q.push_back(v);
        return q;
    endfunction

    task automatic send_word(input logic [31:0] w, input logic l, input logic [1:0] nb);
        logic acc;
        data   = w;
        last   = l;
        nbytes = nb;
        valid  = 1'b1;
        acc    = 1'b0;
        for (int c = 0; c < 200; c++) begin
            acc = ready && en;
            step();
            if (acc) break;
        end
        if (!acc) check("accept_timeout", 512'(0), 512'(1));
    endtask

    task automatic send_msg(input bytes_t m);
        int nw;
        nw = (m.size() + 3) / 4;
        for (int k = 0; k < nw; k++) begin
            logic [31:0] w;
            w = $urandom;
            for (int b = 0; b < 4; b++) begin
                if (4*k + b < m.size()) w[8*b +: 8] = m[4*k + b];
            end
            send_word(w, k == nw - 1, 2'(m.size() % 4));
        end
`ifdef MD5_PAD_OVERFLOW_EN
        if (m.size() > MAX) exp_err++;
        else expv_q.push_back(model(m));
`else
        expv_q.push_back(model(m));
`endif
    endtask

    task automatic drain(output logic [511:0] lastb);
        logic [511:0] g, e;
        valid = 1'b0;
        last  = 1'b0;
        for (int c = 0; c < 150; c++) begin
            if (got_q.size() >= expv_q.size() && err_cnt >= exp_err) break;
            step();
        end
        repeat (4) step();
        check("blk_count", 512'(got_q.size()), 512'(expv_q.size()));
`ifdef MD5_PAD_OVERFLOW_EN
        check("err_count", 512'(err_cnt), 512'(exp_err));
`endif
        lastb = '0;
        while (expv_q.size() > 0 && got_q.size() > 0) begin
            e = expv_q.pop_front();
            g = got_q.pop_front();
            check("block", g, e);
            lastb = g;
        end
        got_q.delete();
        expv_q.delete();
    endtask

    initial begin
        bytes_t       m;
        logic [511:0] blk;
        int           n;

        rst = 1'b1; dir_en = 1'b1; rnd_en = 1'b1; rand_mode = 1'b0;
        valid = 1'b0; last = 1'b0; data = '0; nbytes = '0;
        step();
        step();
        check("rst_wb", wb, 512'(0));
        check("rst_valid", 512'(valid_out), 512'(0));
        rst = 1'b0;
        step();
        check("rst_ready", 512'(ready), 512'(1));

        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m);
        check("abc_latency", 512'(valid_out), 512'(1));
        check("abc_emit_ready", 512'(ready), 512'(0));
        drain(blk);
        check("abc_w0", 512'(blk[31:0]), 512'(32'h80636261));
        check("abc_w14", 512'(blk[479:448]), 512'(32'h18));

        m = '{8'h61, 8'h62, 8'h63, 8'h64};
        send_msg(m);
        drain(blk);
        check("abcd_w0", 512'(blk[31:0]), 512'(32'h64636261));
        check("abcd_w1", 512'(blk[63:32]), 512'(32'h00000080));
        check("abcd_w14", 512'(blk[479:448]), 512'(32'h20));

        m = const_msg(55, 8'h41);
        send_msg(m);
        drain(blk);
        check("len55_w13", 512'(blk[447:416]), 512'(32'h80414141));
        check("len55_w14", 512'(blk[479:448]), 512'(32'h1B8));

        m = const_msg(56, 8'h41);
        send_msg(m);
        drain(blk);
`ifndef MD5_PAD_OVERFLOW_EN
        check("len56_w13", 512'(blk[447:416]), 512'(32'h80414141));
        check("len56_w14", 512'(blk[479:448]), 512'(32'h1B8));
`endif

        // Next word held on the bus through a frozen EMIT.
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m);
        dir_en = 1'b0;
        data = 32'h64636261; last = 1'b1; nbytes = 2'd0; valid = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            check("en_off_valid", 512'(valid_out), 512'(0));
            check("en_off_ready", 512'(ready), 512'(0));
            step();
        end
        dir_en = 1'b1;
        #1;
        check("en_on_valid", 512'(valid_out), 512'(1));
        m = '{8'h61, 8'h62, 8'h63, 8'h64};
        send_msg(m);
        drain(blk);

        send_word(32'h11223344, 1'b0, 2'd0);
        send_word(32'h55667788, 1'b0, 2'd0);
        valid = 1'b0;
        rst = 1'b1;
        step();
        check("midrst_valid", 512'(valid_out), 512'(0));
        rst = 1'b0;
        step();
        m = '{8'h61, 8'h62, 8'h63};
        send_msg(m);
        drain(blk);

        rand_mode = 1'b1;
        for (int t = 0; t < 25; t++) begin
            m.delete();
            n = $urandom_range(1, 60);
            for (int j = 0; j < n; j++) m.push_back(8'($urandom));
            send_msg(m);
            drain(blk);
        end
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
